sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Synchronous front-end that sequences set/clear requests into safe s/r/en drive for the downstream level-sensitive SR latch (srlatch).
- Guarantees s and r are never both 1 and keeps s/r stable for a setup window before en rises and for one hold cycle after en falls.
- Drives en only during a pulse of programmable width.
- Keeps a shadow of the expected latch state for the rest of the control logic.

Parameters:
- SETUP_CYC, 1: cycles s/r are driven with en=0 before the enable pulse. Legal range 1..2**CNT_W-1.
- PULSE_CYC, 2: cycles en is held at 1. Legal range 1..2**CNT_W-1.
- CNT_W, 4: width of the internal phase counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- set_req  input  1  request to set the latch; sampled every edge.
- clr_req  input  1  request to clear the latch; sampled every edge.
- busy  output  1  1 while a sequence is in SETUP, PULSE or HOLD.
- s  output  1  latch S drive.
- r  output  1  latch R drive.
- en  output  1  latch enable drive.
- done  output  1  one-cycle pulse when a sequence completes.
- q_shadow  output  1  expected latch Q after the last completed sequence.
- q_valid  output  1  1 once any sequence has completed since reset.
- conflict  output  1  one-cycle pulse when set_req and clr_req are sampled high on the same edge.

Behaviour:
- Reset values: busy, s, r, en, done, q_shadow, q_valid and conflict are all 0. The FSM is in IDLE, the counter is 0 and the pending bits are cleared.
- Reset dominates every other input on the same edge. It applies mid-sequence: en, s and r drop to 0 on the next edge.
- States:
  - IDLE: s=r=en=0, busy=0.
  - SETUP: s or r=1, en=0.
  - PULSE: s or r=1, en=1.
  - HOLD: s or r=1, en=0.
- Pending capture (every cycle, any state):
  - set_req alone sets pend_set and clears pend_clr.
  - clr_req alone sets pend_clr and clears pend_set (last request wins).
  - Both together: pend_clr=1, pend_set=0, and conflict pulses on the next cycle (clear has priority).
- IDLE: the effective request is the pending bits OR'ed with the same-cycle inputs, with the same priority rules.
  - If a request exists, latch op (SET or CLR), clear the pending bits, load counter=SETUP_CYC-1 and go to SETUP.
  - The op register drives s=(op==SET) and r=(op==CLR) from SETUP through HOLD inclusive.
- SETUP: when counter==0, load PULSE_CYC-1 and go to PULSE; otherwise decrement.
- PULSE: when counter==0, go to HOLD; otherwise decrement.
- HOLD: one cycle, then go to IDLE unconditionally. There is always at least one IDLE cycle with s=r=en=0 between sequences. On the HOLD->IDLE edge, done=1, q_shadow=(op==SET) and q_valid=1.
- Requests arriving while busy are never applied to the running sequence, are never dropped, and launch from IDLE.
- Invariant: s&r==0 on every cycle. en=1 only in PULSE. s/r never change while busy.
- Latency (defaults), set_req high at edge N:
  - N+1: SETUP, s=1.
  - N+2 and N+3: en=1.
  - N+4: HOLD, en=0, s=1.
  - N+5: IDLE, s=0, done=1, q_shadow=1.
  - busy is high N+1..N+4.
- The counter never wraps. Parameter values outside the legal range are unsupported.

Optional Feature:
- Macro: SRLD_SKIP_REDUNDANT_EN.
- Defined: in IDLE, a request where q_valid=1 and the target equals q_shadow is consumed with no sequence. The pending bit clears, s/r/en/busy stay 0, and done pulses one cycle on the next edge.
- Undefined: every request runs a full SETUP/PULSE/HOLD sequence regardless of q_shadow.

Test Plan:
- Reset then set_req for 1 cycle at edge 10 -> s=1 on cycles 11-14, en=1 on 12-13, done=1 and q_shadow=1 on 15, r=0 throughout.
- set_req and clr_req together at edge 20 -> conflict=1 on cycle 21, r=1 sequence runs, s stays 0, q_shadow=0 at done.
- During a set sequence, clr_req at edge 13 and then set_req at edge 14 -> running sequence unaffected, exactly one follow-on SET sequence starts after one IDLE cycle, and no CLR sequence runs.
- rst asserted during PULSE -> next cycle en=s=r=busy=0, q_valid=0, no done, pending cleared.
- Parameters SETUP_CYC=3, PULSE_CYC=1 -> en high exactly 1 cycle, starting 3 cycles after s rises. An assertion on s&r==0 and on s/r stability while busy holds for 1000 random requests.
- With SRLD_SKIP_REDUNDANT_EN, after a completed SET, set_req again -> en stays 0, done pulses 1 cycle later. Without the macro, a full sequence runs.

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// Sequences set/clear requests into safe s/r/en drive for a downstream
// level-sensitive SR latch.
//   - s and r are never high together.
//   - s/r are held stable for a setup window before en rises.
//   - s/r are held for one hold cycle after en falls.
//   - A shadow copy of the expected latch Q is kept for other logic.
// Optional feature macro: SRLD_SKIP_REDUNDANT_EN
//   When defined, an idle request whose target already matches a valid
//   q_shadow is consumed without driving the latch. done still pulses.

module sr_latch_driver #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic busy,
    output logic s,
    output logic r,
    output logic en,
    output logic done,
    output logic q_shadow,
    output logic q_valid,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             op_set;
    logic             pend_set;
    logic             pend_clr;

    logic             cap_set;
    logic             cap_clr;
    logic             eff_set;
    logic             eff_clr;
    logic             have_req;
    logic             req_is_set;
    logic             skip_req;

    // Next pending bits (last request wins, clear wins a tie) and the
    // effective idle request, which merges stored and same-cycle requests.
    always_comb begin
        cap_set = pend_set;
        cap_clr = pend_clr;
        if (clr_req) begin
            cap_set = 1'b0;
            cap_clr = 1'b1;
        end else if (set_req) begin
            cap_set = 1'b1;
            cap_clr = 1'b0;
        end

        eff_set    = pend_set | set_req;
        eff_clr    = pend_clr | clr_req;
        have_req   = eff_set | eff_clr;
        req_is_set = ~eff_clr;

`ifdef SRLD_SKIP_REDUNDANT_EN
        skip_req = q_valid & (req_is_set == q_shadow);
`else
        skip_req = 1'b0;
`endif
    end

    // Sequencer FSM, pending capture and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op_set   <= 1'b0;
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
            busy     <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            en       <= 1'b0;
            done     <= 1'b0;
            q_shadow <= 1'b0;
            q_valid  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= set_req & clr_req;
            done     <= 1'b0;
            pend_set <= cap_set;
            pend_clr <= cap_clr;

            case (state)
                IDLE: begin
                    if (have_req) begin
                        pend_set <= 1'b0;
                        pend_clr <= 1'b0;
                        if (skip_req) begin
                            done <= 1'b1;
                        end else begin
                            op_set <= req_is_set;
                            s      <= req_is_set;
                            r      <= ~req_is_set;
                            busy   <= 1'b1;
                            count  <= SETUP_LOAD;
                            state  <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    if (count == '0) begin
                        count <= PULSE_LOAD;
                        en    <= 1'b1;
                        state <= PULSE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end

                PULSE: begin
                    if (count == '0) begin
                        en    <= 1'b0;
                        state <= HOLD;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end

                HOLD: begin
                    s        <= 1'b0;
                    r        <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    q_shadow <= op_set;
                    q_valid  <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    s     <= 1'b0;
                    r     <= 1'b0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver
// Drives two sr_latch_driver instances (default timing, and SETUP_CYC=3 /
// PULSE_CYC=1) with the same request stream and compares every output,
// every cycle, against a sequence-age reference model.
// Honours SRLD_SKIP_REDUNDANT_EN when it is defined for the build.

module tb_sr_latch_driver;

`ifdef SRLD_SKIP_REDUNDANT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;

    logic busy0, s0, r0, en0, done0, qsh0, qv0, conf0;
    logic busy1, s1, r1, en1, done1, qsh1, qv1, conf1;

    int checks = 0;
    int failures = 0;

    // Reference model state, one slot per instance
    int cfg_setup [2] = '{1, 3};
    int cfg_pulse [2] = '{2, 1};
    bit m_active  [2];
    int m_age     [2];
    bit m_op      [2];
    int m_pend    [2];
    bit m_qsh     [2];
    bit m_qval    [2];
    bit m_done    [2];
    bit m_conf    [2];

    string names [8] = '{"busy", "s", "r", "en", "done", "q_shadow", "q_valid", "conflict"};

    sr_latch_driver #(.SETUP_CYC(1), .PULSE_CYC(2), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .busy(busy0), .s(s0), .r(r0), .en(en0), .done(done0),
        .q_shadow(qsh0), .q_valid(qv0), .conflict(conf0)
    );

    sr_latch_driver #(.SETUP_CYC(3), .PULSE_CYC(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .busy(busy1), .s(s1), .r(r1), .en(en1), .done(done1),
        .q_shadow(qsh1), .q_valid(qv1), .conflict(conf1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the reference model by one clock edge for instance i
    task automatic modelStep(input int i, input bit rv, input bit sv, input bit cv);
        bit want_set;
        bit want_clr;
        bit target;
        if (rv) begin
            m_active[i] = 1'b0;
            m_age[i]    = 0;
            m_op[i]     = 1'b0;
            m_pend[i]   = 0;
            m_qsh[i]    = 1'b0;
            m_qval[i]   = 1'b0;
            m_done[i]   = 1'b0;
            m_conf[i]   = 1'b0;
            return;
        end
        m_conf[i] = sv && cv;
        m_done[i] = 1'b0;
        if (m_active[i]) begin
            m_age[i]++;
            if (m_age[i] > cfg_setup[i] + cfg_pulse[i] + 1) begin
                m_active[i] = 1'b0;
                m_done[i]   = 1'b1;
                m_qsh[i]    = m_op[i];
                m_qval[i]   = 1'b1;
            end
            if (cv)      m_pend[i] = 2;
            else if (sv) m_pend[i] = 1;
        end else begin
            want_clr = (m_pend[i] == 2) || cv;
            want_set = (m_pend[i] == 1) || sv;
            if (want_clr || want_set) begin
                target    = !want_clr;
                m_pend[i] = 0;
                if (SKIP && m_qval[i] && (target == m_qsh[i])) begin
                    m_done[i] = 1'b1;
                end else begin
                    m_active[i] = 1'b1;
                    m_age[i]    = 1;
                    m_op[i]     = target;
                end
            end
        end
    endtask

    // Compare all outputs of instance i against the model
    task automatic checkInstance(input int i, input logic [7:0] obs);
        logic [7:0] exp_v;
        bit exp_en;
        exp_en = m_active[i] && (m_age[i] > cfg_setup[i]) &&
                 (m_age[i] <= cfg_setup[i] + cfg_pulse[i]);
        exp_v = {m_active[i], m_active[i] && m_op[i], m_active[i] && !m_op[i],
                 exp_en, m_done[i], m_qsh[i], m_qval[i], m_conf[i]};
        for (int b = 0; b < 8; b++) begin
            checkOutput($sformatf("u%0d.%s", i, names[b]), int'(obs[7-b]), int'(exp_v[7-b]));
        end
        checkOutput($sformatf("u%0d.sr_excl", i), int'(obs[6] & obs[5]), 0);
    endtask

    // Drive one cycle of inputs, then check both instances after the edge
    task automatic applyStimulus(input bit rv, input bit sv, input bit cv);
        @(negedge clk);
        rst     = rv;
        set_req = sv;
        clr_req = cv;
        @(posedge clk);
        #1;
        modelStep(0, rv, sv, cv);
        modelStep(1, rv, sv, cv);
        checkInstance(0, {busy0, s0, r0, en0, done0, qsh0, qv0, conf0});
        checkInstance(1, {busy1, s1, r1, en1, done1, qsh1, qv1, conf1});
    endtask

    // Directed scenarios followed by randomized requests and resets
    initial begin
        // Reset
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);

        // Single set request
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);

        // Simultaneous set and clear: clear wins, conflict pulses
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);

        // Clear then set while busy: only a follow-on SET runs
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (14) applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset during PULSE, with a request pending
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);

        // Redundant set after a completed set
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);

        // Random requests with occasional reset
        for (int n = 0; n < 1000; n++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0);
        end
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
